// File: rtl/brnch_pred_nbit_bht.sv
// Dynamic branch predictor: 2**IDX_W-entry table of CTR_W-bit saturating counters.
// Define BRNCH_PRED_GSHARE_EN to XOR a non-speculative global history register into the index.
module brnch_pred_nbit_bht #(
  parameter int IDX_W      = 5,
  parameter int CTR_W      = 2,
  parameter int MISS_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_is_branch,
  input  logic [IDX_W-1:0]      if_pc_idx,
  input  logic                  id_stall,
  input  logic                  id_actual_taken,
  output logic                  pred_taken,
  output logic                  flush,
  output logic [MISS_CNT_W-1:0] miss_cnt
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((2 ** (CTR_W - 1)) - 1);

  function automatic logic [CTR_W-1:0] ctr_train(input logic [CTR_W-1:0] c,
                                                 input logic taken);
    if (taken) return (c == '1) ? c : c + CTR_W'(1);
    else       return (c == '0) ? c : c - CTR_W'(1);
  endfunction

  function automatic logic [MISS_CNT_W-1:0] miss_sat_inc(input logic [MISS_CNT_W-1:0] c);
    return (c == '1) ? c : c + MISS_CNT_W'(1);
  endfunction

  logic [CTR_W-1:0] ctr_tbl [DEPTH];
  logic [IDX_W-1:0] eff_idx;
  logic             res;
  logic             id_vld_p1;
  logic             id_pred_p1;
  logic [IDX_W-1:0] id_idx_p1;

`ifdef BRNCH_PRED_GSHARE_EN
  logic [IDX_W-1:0] ghr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ghr <= '0;
    else if (res) ghr <= IDX_W'({ghr, id_actual_taken});
  end

  assign eff_idx = if_pc_idx ^ ghr;
`else
  assign eff_idx = if_pc_idx;
`endif

  // IF stage: lookup returns the pre-update counter on a same-index collision
  assign pred_taken = if_is_branch & ctr_tbl[eff_idx][CTR_W-1] & ~id_stall;

  // IF -> ID pipe register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_vld_p1  <= 1'b0;
      id_pred_p1 <= 1'b0;
      id_idx_p1  <= '0;
    end else if (!id_stall) begin
      id_vld_p1  <= if_is_branch & ~flush;
      id_pred_p1 <= pred_taken;
      id_idx_p1  <= eff_idx;
    end
  end

  // ID stage: resolve, flush, train
  assign res   = id_vld_p1 & ~id_stall;
  assign flush = res & (id_actual_taken != id_pred_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ctr_tbl[i] <= CTR_INIT;
    end else if (res) begin
      ctr_tbl[id_idx_p1] <= ctr_train(ctr_tbl[id_idx_p1], id_actual_taken);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     miss_cnt <= '0;
    else if (flush) miss_cnt <= miss_sat_inc(miss_cnt);
  end

endmodule

// File: tb/tb_brnch_pred_nbit_bht.sv
// Bench for brnch_pred_nbit_bht: directed test-plan sequences plus random traffic vs. a table model.
module tb_brnch_pred_nbit_bht;
  localparam int IDX_W      = 5;
  localparam int CTR_W      = 2;
  localparam int MISS_CNT_W = 4;
  localparam int DEPTH = 1 << IDX_W;
  localparam int CMAX  = (1 << CTR_W) - 1;
  localparam int CHALF = 1 << (CTR_W - 1);
  localparam int MMAX  = (1 << MISS_CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic if_is_branch = 1'b0;
  logic [IDX_W-1:0] if_pc_idx = '0;
  logic id_stall = 1'b0;
  logic id_actual_taken = 1'b0;
  logic pred_taken;
  logic flush;
  logic [MISS_CNT_W-1:0] miss_cnt;

  int n_chk = 0;
  int n_err = 0;

  // reference model: counters as plain integers, one pending branch slot
  int m_ctr [DEPTH];
  bit m_vld;
  bit m_pred;
  int m_idx;
  int m_miss;
  int m_ghr;

  brnch_pred_nbit_bht #(.IDX_W(IDX_W), .CTR_W(CTR_W), .MISS_CNT_W(MISS_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .if_is_branch(if_is_branch), .if_pc_idx(if_pc_idx),
    .id_stall(id_stall), .id_actual_taken(id_actual_taken),
    .pred_taken(pred_taken), .flush(flush), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_ctr[i] = CHALF - 1;
    m_vld = 0; m_pred = 0; m_idx = 0; m_miss = 0; m_ghr = 0;
  endtask

  task automatic step(input bit br, input int idx, input bit stall, input bit act);
    int eff;
    bit e_pred, res, e_flush;
    @(negedge clk);
    if_is_branch = br;
    if_pc_idx = IDX_W'(idx);
    id_stall = stall;
    id_actual_taken = act;
    eff = idx;
`ifdef BRNCH_PRED_GSHARE_EN
    eff = idx ^ m_ghr;
`endif
    e_pred = br && !stall && (m_ctr[eff] >= CHALF);
    res = m_vld && !stall;
    e_flush = res && (act != m_pred);
    #2;
    check("pred_taken", int'(pred_taken), int'(e_pred));
    check("flush", int'(flush), int'(e_flush));
    check("miss_cnt", int'(miss_cnt), m_miss);
    @(posedge clk);
    if (res) begin
      if (act) m_ctr[m_idx] = (m_ctr[m_idx] < CMAX) ? m_ctr[m_idx] + 1 : CMAX;
      else     m_ctr[m_idx] = (m_ctr[m_idx] > 0) ? m_ctr[m_idx] - 1 : 0;
      m_ghr = ((m_ghr << 1) | int'(act)) & (DEPTH - 1);
    end
    if (e_flush && m_miss < MMAX) m_miss++;
    if (!stall) begin
      m_vld = br && !e_flush;
      m_pred = e_pred;
      m_idx = eff;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    if_is_branch = 1'b1;
    if_pc_idx = IDX_W'(3);
    id_stall = 1'b0;
    id_actual_taken = 1'b1;
    model_reset();
    #2;
    check("rst_pred", int'(pred_taken), 0);
    check("rst_flush", int'(flush), 0);
    check("rst_miss", int'(miss_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    if_is_branch = 1'b0;
  endtask

  initial begin
    model_reset();
    pulse_reset();

    // first mispredict trains idx 3 to weakly taken
    step(1, 3, 0, 0);
    step(0, 0, 0, 1);
    step(1, 3, 0, 1);
    step(0, 0, 0, 1);
    // saturation at idx 7, then one not-taken
    for (int i = 0; i < 6; i++) step(1, 7, 0, 1);
    step(1, 7, 0, 1);
    step(0, 0, 0, 0);
    step(1, 7, 0, 0);
    // stall hold then a single mismatching resolve
    step(1, 9, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 9, 1, 1);
    step(0, 0, 0, 1);
    // flush squashes a same-cycle IF branch at idx 9
    step(1, 12, 0, 0);
    step(1, 9, 0, 1);
    step(0, 0, 0, 1);
    step(1, 9, 0, 0);
    // same-index collision at idx 4
    step(1, 4, 0, 0);
    step(1, 4, 0, 1);
    step(1, 4, 0, 1);

    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) pulse_reset();
      step(($urandom % 4) != 0,
           ($urandom % 8 == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 7)),
           ($urandom % 4) == 0,
           ($urandom % 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
